// File: rtl/fir_error_monitor.sv
// Error-statistics monitor for approximate FIR outputs: accumulates the signed
// sum, sum of squares and peak magnitude of (approx - exact) over one window.
module fir_error_monitor #(
    parameter int W     = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic [W-1:0]     approx_in,
    input  logic [W-1:0]     exact_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_err,
    output logic [ACC_W-1:0] sum_sq,
    output logic [W:0]       max_abs,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int SQ_W     = 2 * W + 2;
    localparam int SQ_SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   win_len_q;
    logic               start_ok;
    logic               xfer;
    logic               last_xfer;

    logic               s1_valid;
    logic signed [W:0]  s1_e;
    logic [W:0]         abs_e;
    logic signed [SQ_W-1:0] sq_s;
    logic [SQ_W-1:0]    sq_e;
    logic [ACC_W:0]     err_wide;
    logic               err_sat;
    logic [ACC_W-1:0]   sum_err_nxt;
    logic [SQ_SUM_W-1:0] sq_wide;
    logic               sq_sat;
    logic [ACC_W-1:0]   sum_sq_nxt;

    assign start_ok  = start && (win_len != '0) && ((state == IDLE) || (state == DONE));
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && ((count + CNT_W'(1)) == win_len_q);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_xfer) state_nxt = DRAIN;
            end
            // Stage 1 holds the final pair here; stage 2 retires it on this edge.
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) state_nxt = ACCUM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage-2 arithmetic is done one bit wider than the accumulators so that a
    // carry out of range can be detected and clamped instead of wrapping.
    always_comb begin
        abs_e    = s1_e[W] ? W'(0) - s1_e : s1_e;
        sq_s     = SQ_W'(s1_e) * SQ_W'(s1_e);
        sq_e     = sq_s;
        err_wide = {sum_err[ACC_W-1], sum_err} + (ACC_W+1)'(s1_e);
        err_sat  = err_wide[ACC_W] != err_wide[ACC_W-1];
        if (!err_sat)
            sum_err_nxt = err_wide[ACC_W-1:0];
        else if (err_wide[ACC_W])
            sum_err_nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sum_err_nxt = {1'b0, {(ACC_W-1){1'b1}}};
        sq_wide    = SQ_SUM_W'(sum_sq) + SQ_SUM_W'(sq_e);
        sq_sat     = |sq_wide[SQ_SUM_W-1:ACC_W];
        sum_sq_nxt = sq_sat ? {ACC_W{1'b1}} : sq_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_len_q <= '0;
            count     <= '0;
            s1_valid  <= 1'b0;
            s1_e      <= '0;
            sum_err   <= '0;
            sum_sq    <= '0;
            max_abs   <= '0;
            ovf       <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= xfer;
            if (xfer)
                s1_e <= $signed({approx_in[W-1], approx_in}) - $signed({exact_in[W-1], exact_in});
            if (start_ok) begin
                win_len_q <= win_len;
                count     <= '0;
                sum_err   <= '0;
                sum_sq    <= '0;
                max_abs   <= '0;
                ovf       <= 1'b0;
            end else begin
                if (xfer)
                    count <= count + CNT_W'(1);
                if (s1_valid) begin
                    sum_err <= sum_err_nxt;
                    sum_sq  <= sum_sq_nxt;
                    if (abs_e > max_abs)
                        max_abs <= abs_e;
                    if (err_sat || sq_sat)
                        ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_error_monitor.sv
// Randomized self-checking bench for fir_error_monitor: a wide-accumulator and a
// narrow (saturating) instance share stimulus and are checked against a list model.
module tb_fir_error_monitor;

    localparam int W     = 16;
    localparam int CNT_W = 16;
    localparam int ACC_W = 48;
    localparam int ACC_S = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic [W-1:0]     approx_in;
    logic [W-1:0]     exact_in;
    logic             in_valid;

    logic             in_ready, busy, done, ovf;
    logic [ACC_W-1:0] sum_err, sum_sq;
    logic [W:0]       max_abs;
    logic [CNT_W-1:0] count;

    logic             in_ready_s, busy_s, done_s, ovf_s;
    logic [ACC_S-1:0] sum_err_s, sum_sq_s;
    logic [W:0]       max_abs_s;
    logic [CNT_W-1:0] count_s;

    int tests_run    = 0;
    int tests_failed = 0;

    int acc_e[$];
    int dir_a[$];
    int dir_x[$];

    fir_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .approx_in(approx_in), .exact_in(exact_in), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .sum_err(sum_err),
        .sum_sq(sum_sq), .max_abs(max_abs), .count(count), .ovf(ovf)
    );

    fir_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_s (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .approx_in(approx_in), .exact_in(exact_in), .in_valid(in_valid),
        .in_ready(in_ready_s), .busy(busy_s), .done(done_s), .sum_err(sum_err_s),
        .sum_sq(sum_sq_s), .max_abs(max_abs_s), .count(count_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Statistics of the accepted error list, clamped step by step at accw bits.
    task automatic modelResults(input int accw, output longint s, output longint q,
                                output longint m, output longint o);
        longint hi, lo, qmax, ae;
        hi   = (longint'(1) << (accw - 1)) - 1;
        lo   = -(longint'(1) << (accw - 1));
        qmax = (longint'(1) << accw) - 1;
        s = 0; q = 0; m = 0; o = 0;
        foreach (acc_e[i]) begin
            s = s + acc_e[i];
            if (s > hi) begin s = hi; o = 1; end
            else if (s < lo) begin s = lo; o = 1; end
            q = q + longint'(acc_e[i]) * longint'(acc_e[i]);
            if (q > qmax) begin q = qmax; o = 1; end
            ae = (acc_e[i] < 0) ? -longint'(acc_e[i]) : longint'(acc_e[i]);
            if (ae > m) m = ae;
        end
    endtask

    task automatic checkResults(input string tag);
        longint s, q, m, o;
        modelResults(ACC_W, s, q, m, o);
        checkOutput({tag, ".sum_err"}, longint'($signed(sum_err)), s);
        checkOutput({tag, ".sum_sq"}, longint'(sum_sq), q);
        checkOutput({tag, ".max_abs"}, longint'(max_abs), m);
        checkOutput({tag, ".ovf"}, longint'(ovf), o);
        checkOutput({tag, ".count"}, longint'(count), longint'(acc_e.size()));
        modelResults(ACC_S, s, q, m, o);
        checkOutput({tag, ".sum_err_s"}, longint'($signed(sum_err_s)), s);
        checkOutput({tag, ".sum_sq_s"}, longint'(sum_sq_s), q);
        checkOutput({tag, ".max_abs_s"}, longint'(max_abs_s), m);
        checkOutput({tag, ".ovf_s"}, longint'(ovf_s), o);
    endtask

    task automatic randomSample(output int v);
        logic signed [W-1:0] r;
        if ($urandom_range(0, 3) == 0)
            v = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        else begin
            r = W'($urandom);
            v = int'(r);
        end
    endtask

    // One full window: start, accept len pairs, drain with a stray pair, check results.
    task automatic applyStimulus(input string tag, input int len, input bit stray_start,
                                 input bit hold_valid);
        int accepted, cycles, a, x;
        acc_e.delete();
        start = 1'b1; win_len = CNT_W'(len); in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, ".busy_start"}, longint'(busy), 1);
        checkOutput({tag, ".done_clr"}, longint'(done), 0);
        checkOutput({tag, ".ovf_clr_s"}, longint'(ovf_s), 0);
        accepted = 0;
        cycles   = 0;
        while (accepted < len) begin
            in_valid = hold_valid || (cycles > 20) || ($urandom_range(0, 9) < 6);
            if (in_valid && dir_a.size() > 0) begin
                a = dir_a.pop_front();
                x = dir_x.pop_front();
            end else begin
                randomSample(a);
                randomSample(x);
            end
            approx_in = W'(a);
            exact_in  = W'(x);
            if (stray_start && cycles == 0) begin
                start   = 1'b1;
                win_len = CNT_W'(1);
            end
            checkOutput({tag, ".in_ready"}, longint'(in_ready), 1);
            checkOutput({tag, ".count_live"}, longint'(count), accepted);
            @(posedge clk); #1;
            start = 1'b0;
            if (in_valid) begin
                acc_e.push_back(a - x);
                accepted++;
            end
            cycles++;
        end
        in_valid = 1'b1;
        randomSample(a); randomSample(x);
        approx_in = W'(a);
        exact_in  = W'(x);
        checkOutput({tag, ".in_ready_drain"}, longint'(in_ready), 0);
        checkOutput({tag, ".busy_drain"}, longint'(busy), 1);
        checkOutput({tag, ".done_early"}, longint'(done), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, ".done"}, longint'(done), 1);
        checkOutput({tag, ".done_s"}, longint'(done_s), 1);
        checkOutput({tag, ".busy_done"}, longint'(busy), 0);
        checkResults(tag);
    endtask

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; win_len = '0; approx_in = '0; exact_in = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        acc_e.delete();
        checkOutput("reset.in_ready", longint'(in_ready), 0);
        checkOutput("reset.busy", longint'(busy), 0);
        checkOutput("reset.done", longint'(done), 0);
        checkResults("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        repeat (4) begin dir_a.push_back(100); dir_x.push_back(100); end
        applyStimulus("exact", 4, 1'b0, 1'b1);

        dir_a = '{10, -5, 0};
        dir_x = '{7, -1, 2};
        applyStimulus("mixed", 3, 1'b0, 1'b0);

        dir_a = '{32767, 32767};
        dir_x = '{-32768, -32768};
        applyStimulus("extreme", 2, 1'b0, 1'b1);

        dir_a = '{0, 0};
        dir_x = '{1000, 1000};
        applyStimulus("saturate", 2, 1'b0, 1'b1);

        applyStimulus("boundary", 2, 1'b1, 1'b1);
        start = 1'b1; win_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("zero_len.done", longint'(done), 1);
        checkOutput("zero_len.busy", longint'(busy), 0);
        checkResults("zero_len");

        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(1, 10);
            applyStimulus($sformatf("rand%0d", i), len, 1'b0, 1'b0);
        end

        acc_e.delete();
        start = 1'b1; win_len = CNT_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; approx_in = W'(5); exact_in = W'(0);
            acc_e.push_back(5);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResults("midwin");
        rst = 1'b1;
        #1;
        acc_e.delete();
        checkOutput("midrst.busy", longint'(busy), 0);
        checkOutput("midrst.in_ready", longint'(in_ready), 0);
        checkResults("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("postrst.done", longint'(done), 0);
        checkOutput("postrst.busy", longint'(busy), 0);
        checkOutput("postrst.count", longint'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
